// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the multiplexed ADC scan controller.
// No ports: state enum, default parameters and width helpers.
package adc_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONVERT,
    ST_ADVANCE
  } scan_state_e;

  localparam int DEF_N_CH         = 8;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_DIV          = 500000;
  localparam int DEF_SETTLE_TICKS = 1;
  localparam int DEF_CONV_TICKS   = 4;
  localparam int DEF_HYST         = 8;

  // Address width for a channel count.
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  // Counter width able to hold 0..n-1 (never zero bits).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/argmin_tree.sv
// Combinational minimum / argmin over N_CH masked inputs.
// Ports: data_i (per-channel values), valid_i (include mask),
// min_o (smallest valid value, all-ones if none), idx_o (its index).
module argmin_tree
  import adc_scan_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int AW     = addr_w(N_CH)
) (
  input  logic [N_CH-1:0][DATA_W-1:0] data_i,
  input  logic [N_CH-1:0]             valid_i,
  output logic [DATA_W-1:0]           min_o,
  output logic [AW-1:0]               idx_o
);

  logic found;

  // Ascending scan with strict '<': an equal value at a higher
  // index never displaces the current winner.
  always_comb begin
    min_o = '1;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (valid_i[i] && (!found || data_i[i] < min_o)) begin
        min_o = data_i[i];
        idx_o = AW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_controller.sv
// Steps an external muxed ADC over masked channels, captures samples and
// publishes the per-frame darkest channel plus a hysteretic detect flag.
// Ports: CLK100MHZ/reset (sync, active-high), enable, ch_mask, thresh,
// adc_data in; adc_start, adc_addr, sample_valid/ch/data, frame_done,
// min_val, min_addr, move_goalie out.
module adc_scan_controller
  import adc_scan_pkg::*;
#(
  parameter  int N_CH         = DEF_N_CH,
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int DIV          = DEF_DIV,
  parameter  int SETTLE_TICKS = DEF_SETTLE_TICKS,
  parameter  int CONV_TICKS   = DEF_CONV_TICKS,
  parameter  int HYST         = DEF_HYST,
  localparam int AW           = addr_w(N_CH)
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [DATA_W-1:0] thresh,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_start,
  output logic [AW-1:0]     adc_addr,
  output logic              sample_valid,
  output logic [AW-1:0]     sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic              frame_done,
  output logic [DATA_W-1:0] min_val,
  output logic [AW-1:0]     min_addr,
  output logic              move_goalie
);

  localparam int DW = cnt_w(DIV);
  localparam int TW = cnt_w(max_i(SETTLE_TICKS, CONV_TICKS));
  localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);

  scan_state_e                  state_q;
  logic [DW-1:0]                div_q;
  logic [TW-1:0]                tcnt_q;
  logic                         adc_start_q;
  logic [AW-1:0]                adc_addr_q;
  logic [N_CH-1:0]              frame_mask_q;
  logic [N_CH-1:0][DATA_W-1:0]  slot_q;
  logic                         sample_valid_q;
  logic [AW-1:0]                sample_ch_q;
  logic [DATA_W-1:0]            sample_data_q;
  logic                         frame_done_q;
  logic [DATA_W-1:0]            min_val_q;
  logic [AW-1:0]                min_addr_q;
  logic                         move_q;
  logic                         move_d;

  logic                         tick;
  logic                         nxt_found;
  logic [AW-1:0]                nxt_addr;
  logic [AW-1:0]                low_addr;
  logic [DATA_W-1:0]            am_val;
  logic [AW-1:0]                am_idx;
  logic [DATA_W:0]              hyst_lim;

  assign tick = (div_q == DW'(DIV - 1));

  // Next masked channel above the current address, and the lowest
  // channel of the incoming mask for the start of a frame.
  always_comb begin
    nxt_found = 1'b0;
    nxt_addr  = '0;
    low_addr  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (frame_mask_q[i] && i > int'(adc_addr_q)) begin
        nxt_found = 1'b1;
        nxt_addr  = AW'(i);
      end
      if (ch_mask[i]) begin
        low_addr = AW'(i);
      end
    end
  end

  argmin_tree #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W)
  ) u_argmin (
    .data_i  (slot_q),
    .valid_i (frame_mask_q),
    .min_o   (am_val),
    .idx_o   (am_idx)
  );

  // Extra bit keeps thresh+HYST from wrapping; past full scale
  // the flag can no longer be released.
  always_comb begin
    hyst_lim = {1'b0, thresh} + HYST_X;
    move_d   = move_q;
    if (am_val < thresh) begin
      move_d = 1'b1;
    end else if ({1'b0, am_val} >= hyst_lim) begin
      move_d = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      div_q          <= '0;
      tcnt_q         <= '0;
      adc_start_q    <= 1'b0;
      adc_addr_q     <= '0;
      frame_mask_q   <= '0;
      slot_q         <= '1;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      frame_done_q   <= 1'b0;
      min_val_q      <= '1;
      min_addr_q     <= '0;
      move_q         <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          div_q       <= '0;
          tcnt_q      <= '0;
          adc_start_q <= 1'b0;
          if (enable && |ch_mask) begin
            frame_mask_q <= ch_mask;
            adc_addr_q   <= low_addr;
            state_q      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          div_q <= tick ? '0 : div_q + DW'(1);
          if (tick) begin
            if (tcnt_q == TW'(SETTLE_TICKS - 1)) begin
              tcnt_q      <= '0;
              adc_start_q <= 1'b1;
              state_q     <= ST_CONVERT;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        ST_CONVERT: begin
          div_q <= tick ? '0 : div_q + DW'(1);
          if (tick) begin
            if (tcnt_q == TW'(CONV_TICKS - 1)) begin
              tcnt_q             <= '0;
              adc_start_q        <= 1'b0;
              slot_q[adc_addr_q] <= adc_data;
              sample_valid_q     <= 1'b1;
              sample_ch_q        <= adc_addr_q;
              sample_data_q      <= adc_data;
              state_q            <= ST_ADVANCE;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        ST_ADVANCE: begin
          // Divider already wrapped to 0 on the final convert tick.
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (nxt_found) begin
            adc_addr_q <= nxt_addr;
            state_q    <= ST_SETTLE;
          end else begin
            min_val_q    <= am_val;
            min_addr_q   <= am_idx;
            move_q       <= move_d;
            frame_done_q <= 1'b1;
            frame_mask_q <= ch_mask;
            if (|ch_mask) begin
              adc_addr_q <= low_addr;
              state_q    <= ST_SETTLE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adc_start    = adc_start_q;
  assign adc_addr     = adc_addr_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign frame_done   = frame_done_q;
  assign min_val      = min_val_q;
  assign min_addr     = min_addr_q;
  assign move_goalie  = move_q;

endmodule
